// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the lab3 stopwatch control block.
//   state_t : top-level control states (RUN, PAUSE, ADJUST)
//   SEL_MIN : adjust-select value that targets the minutes field
//   SEL_SEC : adjust-select value that targets the seconds field
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a stability counter. The debounced
// level only follows the synchronized input after DEB_CYCLES consecutive
// samples that differ from the current level; any sample that agrees with
// the current level restarts the count, so shorter bounce is ignored.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw (asynchronous) button level
//   level_o out debounced button level
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/pause/adjust sequencing for the lab3 stopwatch. Generates one-cycle
// increment strobes for the minutes/seconds datapath (including the
// seconds-to-minutes carry) and the adjust-mode blink phase.
// Optional feature macro: STOPWATCH_BLINK_EN (blink divider and phase logic;
// when undefined blink_min/blink_sec are tied low and BLINK_DIV is ignored).
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   sel       in  raw adjust-field select (0 = minutes, 1 = seconds)
//   adj       in  raw adjust-mode switch
//   pause     in  raw pause push-button; each accepted press toggles run/pause
//   sec_max   in  seconds counter currently holds 59
//   sec_inc   out one-cycle strobe: advance seconds
//   min_inc   out one-cycle strobe: advance minutes
//   running   out high in RUN
//   blink_min out blank minutes digits this phase
//   blink_sec out blank seconds digits this phase
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int ONE_HZ_DIV = 100_000_000,
    parameter int ADJ_DIV    = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    input  logic adj,
    input  logic pause,
    input  logic sec_max,
    output logic sec_inc,
    output logic min_inc,
    output logic running,
    output logic blink_min,
    output logic blink_sec
);

    if (ONE_HZ_DIV < 2 || ADJ_DIV < 2 || BLINK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
        $error("stopwatch_ctrl: divider/debounce parameter out of range");
    end

    localparam int HZ_W  = $clog2(ONE_HZ_DIV);
    localparam int ADJ_W = $clog2(ADJ_DIV);
    localparam logic [HZ_W-1:0]  HZ_TC  = HZ_W'(ONE_HZ_DIV - 1);
    localparam logic [ADJ_W-1:0] ADJ_TC = ADJ_W'(ADJ_DIV - 1);

    state_t           state_q, state_d;
    logic             paused_q, paused_d;
    logic [HZ_W-1:0]  hz_div_q, hz_div_d;
    logic [ADJ_W-1:0] adj_div_q, adj_div_d;
    logic             sec_inc_q, sec_inc_d;
    logic             min_inc_q, min_inc_d;
    logic             adj_s1_q, adj_s2_q;
    logic             sel_s1_q, sel_s2_q;
    logic             pause_level;
    logic             pause_level_prev_q;
    logic             press;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_pause_deb (
        .clk    (clk),
        .rst_n  (reset),
        .btn_i  (pause),
        .level_o(pause_level)
    );

    // A press is the rising edge of the debounced pause level.
    assign press = pause_level & ~pause_level_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adj_s1_q           <= 1'b0;
            adj_s2_q           <= 1'b0;
            sel_s1_q           <= 1'b0;
            sel_s2_q           <= 1'b0;
            pause_level_prev_q <= 1'b0;
        end else begin
            adj_s1_q           <= adj;
            adj_s2_q           <= adj_s1_q;
            sel_s1_q           <= sel;
            sel_s2_q           <= sel_s1_q;
            pause_level_prev_q <= pause_level;
        end
    end

    // Strobes are decoded from the current state, so a tick that coincides
    // with a press or an adj change is still issued; the transition lands
    // on the same edge and takes effect from the next cycle.
    always_comb begin
        state_d   = state_q;
        paused_d  = paused_q ^ press;
        hz_div_d  = hz_div_q;
        adj_div_d = '0;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        unique case (state_q)
            RUN: begin
                hz_div_d  = (hz_div_q == HZ_TC) ? '0 : hz_div_q + HZ_W'(1);
                sec_inc_d = (hz_div_q == HZ_TC);
                min_inc_d = (hz_div_q == HZ_TC) & sec_max;
                if (adj_s2_q) begin
                    state_d = ADJUST;
                end else if (press) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (adj_s2_q) begin
                    state_d = ADJUST;
                end else if (press) begin
                    state_d = RUN;
                end
            end
            ADJUST: begin
                // The 1 Hz divider holds; no carry is generated here.
                adj_div_d = (adj_div_q == ADJ_TC) ? '0 : adj_div_q + ADJ_W'(1);
                sec_inc_d = (adj_div_q == ADJ_TC) & (sel_s2_q == SEL_SEC);
                min_inc_d = (adj_div_q == ADJ_TC) & (sel_s2_q == SEL_MIN);
                if (!adj_s2_q) begin
                    state_d = paused_d ? PAUSE : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            paused_q  <= 1'b0;
            hz_div_q  <= '0;
            adj_div_q <= '0;
            sec_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paused_q  <= paused_d;
            hz_div_q  <= hz_div_d;
            adj_div_q <= adj_div_d;
            sec_inc_q <= sec_inc_d;
            min_inc_q <= min_inc_d;
        end
    end

    assign sec_inc = sec_inc_q;
    assign min_inc = min_inc_q;
    assign running = (state_q == RUN);

`ifdef STOPWATCH_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_div_q, blink_div_d;
    logic             phase_q, phase_d;

    // Divider and phase sit at zero outside ADJUST, so every entry starts
    // with the digits visible.
    always_comb begin
        blink_div_d = '0;
        phase_d     = 1'b0;
        if (state_q == ADJUST) begin
            if (blink_div_q == BLK_TC) begin
                blink_div_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_div_d = blink_div_q + BLK_W'(1);
                phase_d     = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_div_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_div_q <= blink_div_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_min = (state_q == ADJUST) & (sel_s2_q == SEL_MIN) & phase_q;
    assign blink_sec = (state_q == ADJUST) & (sel_s2_q == SEL_SEC) & phase_q;
`else
    assign blink_min = 1'b0;
    assign blink_sec = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and sequencing block for the lab3 stopwatch. Converts raw pause/select/adjust inputs into run, pause and adjust behaviour and issues single-cycle increment strobes to the minutes/seconds counter datapath, including the seconds-to-minutes carry. Also generates the adjust-mode blink phase for the display driver. Sits between the board I/O and the counter/display datapath inside the stopwatch top level.

## Interface
- ONE_HZ_DIV, 100_000_000: clk cycles per run tick (1 Hz); must be ≥2.
- ADJ_DIV, 50_000_000: clk cycles per adjust increment (2 Hz); must be ≥2.
- BLINK_DIV, 25_000_000: clk cycles per blink phase toggle; must be ≥2.
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a pause level change; must be ≥1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds. Raw switch, 2-FF synchronized.
- adj  in  1  adjust mode switch, level. Raw switch, 2-FF synchronized.
- pause  in  1  raw pause push-button. Synchronized and debounced; each accepted press toggles run/pause.
- sec_max  in  1  datapath flag: seconds counter currently holds 59.
- sec_inc  out  1  one-cycle strobe: advance seconds counter. Datapath wraps 59→0.
- min_inc  out  1  one-cycle strobe: advance minutes counter. Datapath wraps 59→0.
- running  out  1  high in RUN state.
- blink_min  out  1  blank minutes digits this phase.
- blink_sec  out  1  blank seconds digits this phase.

## Operation
- States (stopwatch_pkg::state_t): RUN, PAUSE, ADJUST. Separate flag paused_f records the run/pause choice.
- RUN: 1 Hz divider counts 0..ONE_HZ_DIV-1. At terminal count: sec_inc=1. min_inc=1 in the same cycle iff sec_max=1.
- PAUSE: the 1 Hz divider holds its value; it does not clear. Resuming continues the partial second.
- Press event: rising edge of the debounced pause level. In RUN or PAUSE it toggles paused_f and moves to the other state. In ADJUST it toggles paused_f only.
- Synchronized adj=1 enters ADJUST from RUN or PAUSE. The 1 Hz divider holds. The adjust divider clears to 0 on entry.
- ADJUST: at the adjust divider terminal count, sel=0 gives min_inc only and sel=1 gives sec_inc only. No carry is generated, regardless of sec_max.
- adj=0 leaves ADJUST for PAUSE if paused_f=1, otherwise for RUN.
- Blink: phase bit toggles every BLINK_DIV cycles in ADJUST and clears on entry. blink_min = ADJUST & ~sel & phase. blink_sec = ADJUST & sel & phase. Both are 0 outside ADJUST.
- Divider widths are $clog2(DIV). Terminal compare is DIV-1 and the divider wraps to 0 on the next cycle.
- Simultaneous events: outputs are decoded from the current state, so a tick coinciding with a pause press or an adj change is issued, and the transition takes effect next cycle. A sel change mid-ADJUST applies from the next adjust tick and does not clear the adjust divider.

## Timing
- sec_inc and min_inc are registered and asserted for exactly one cycle, in the cycle after the divider holds its terminal value.
- Reset values: state=RUN, paused_f=0, all dividers 0, blink phase 0, debounce counter 0. Outputs: sec_inc=0, min_inc=0, running=1, blink_min=0, blink_sec=0.
- Pause latency: raw edge → 2 sync cycles → DEB_CYCLES stable → debounced level → edge detect → state register. The state changes within DEB_CYCLES+4 cycles of a clean raw edge. Bounce shorter than DEB_CYCLES produces no event.
- adj/sel latency: 2 cycles of synchronization plus 1 cycle to the state register.
- Reset is asynchronous: asserting it mid-operation immediately zeroes all strobes and dividers. Release is synchronized by the top level.

## Configuration
- STOPWATCH_BLINK_EN defined: blink divider and phase logic are present, and the outputs behave as above.
- STOPWATCH_BLINK_EN undefined: the blink logic is not compiled, blink_min and blink_sec are tied to 0, and BLINK_DIV is ignored.

## Structure
- stopwatch_pkg holds:
  - state_t enum (RUN, PAUSE, ADJUST);
  - SEL_MIN=1'b0 and SEL_SEC=1'b1 constants.
- One sub-module, btn_debounce (parameter DEB_CYCLES): 2-FF synchronizer, stability counter and debounced level output. Instantiated once for pause.
- Dividers and the FSM are inline in stopwatch_ctrl.

## Test plan
Parameters for all scenarios: ONE_HZ_DIV=10, ADJ_DIV=4, BLINK_DIV=2, DEB_CYCLES=3.
- Reset and run: hold reset low for 3 cycles, release, sec_max=0 → running=1; sec_inc pulses every 10 cycles; min_inc stays 0.
- Carry: sec_max=1 at a run tick → sec_inc and min_inc both high in the same single cycle.
- Pause and resume: clean pause press 4 cycles after a tick → running=0 and no strobes for 50 cycles. A second press resumes, and the first sec_inc arrives 6 cycles (plus debounce latency) after resume.
- Debounce: pause toggling every cycle for 8 cycles, then low → no state change.
- Adjust: adj=1, sel=1, sec_max=1 → sec_inc every 4 cycles, min_inc never, blink_sec toggles every 2 cycles, blink_min=0. Switching to sel=0 → min_inc every 4 cycles. Pressing pause, then adj=0 → state PAUSE, running=0.
- Async reset mid-count: reset low at divider value 7 → strobes are 0 immediately; after release the first sec_inc arrives 10 cycles later.
